// File: rtl/prod_accum_pkg.sv
// rtl/prod_accum_pkg.sv - shared state encoding, default widths and saturation limits
package prod_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  // Largest positive value of a 64-bit signed word; narrower limits are derived by shifting.
  localparam logic [63:0] SAT_MAX_ALL = 64'h7FFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] sat_max(input int w);
    return SAT_MAX_ALL >> (64 - w);
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// rtl/prod_accum_sat_add.sv - ACC_W-bit signed saturating adder with overflow flag
module sat_add
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] y,
  output logic             ovf
);

  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

  logic [ACC_W-1:0] raw;

  // Overflow only when both operands share a sign that the wrapped sum lost.
  always_comb begin
    raw = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    y   = raw;
    if (ovf) begin
      y = a[ACC_W-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - saturating accumulator of a fixed-length stream of signed products
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] beat_ext;
  logic [ACC_W-1:0] sum;
  logic             sum_ovf;

  assign beat_ext = {{(ACC_W-16){in_data[15]}}, in_data};

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (beat_ext),
    .y   (sum),
    .ovf (sum_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        // Terminating on equality with len keeps the count below its wrap point.
        if (in_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | sum_ovf;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb/tb_prod_accum.sv - directed bench driving a 24-bit and a 17-bit accumulator in lockstep
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, busy_a, ovf_a;
  logic [23:0] acc_a;
  logic        in_ready_b, out_valid_b, busy_b, ovf_b;
  logic [16:0] acc_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(24), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_a), .acc_out(acc_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a), .ovf(ovf_a)
  );

  prod_accum #(.ACC_W(17), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_b), .acc_out(acc_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b), .ovf(ovf_b)
  );

  typedef struct {
    logic [7:0]       len;
    logic [4:0][15:0] b;
    bit               gap;
    int               e24;
    bit               o24;
    int               e17;
    bit               o17;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy_a, 1);
    chk("start_in_ready", in_ready_a, (l != 0) ? 1 : 0);
  endtask

  task automatic send_beat(input logic [15:0] d, input bit gap_after);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready_a && n < 20) begin
      tick();
      n++;
    end
    chk("beat_in_ready", in_ready_a, 1);
    chk("beat_no_early_valid", out_valid_a, 0);
    tick();
    in_valid = 1'b0;
    if (gap_after) begin
      tick();
      chk("gap_no_valid", out_valid_a, 0);
    end
  endtask

  task automatic check_done(input int e24, input bit o24, input int e17, input bit o17);
    chk("done_valid_a", out_valid_a, 1);
    chk("done_valid_b", out_valid_b, 1);
    chk("done_acc_a", $signed(acc_a), e24);
    chk("done_acc_b", $signed(acc_b), e17);
    chk("done_ovf_a", ovf_a, o24);
    chk("done_ovf_b", ovf_b, o17);
  endtask

  task automatic release_done(input int e24);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_idle", busy_a, 0);
    chk("release_valid", out_valid_a, 0);
    chk("release_acc_hold", $signed(acc_a), e24);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{len: 8'd3, b: {16'h0000, 16'h0000, 16'd7, 16'hFFEC, 16'd100}, gap: 1'b0,
               e24: 87, o24: 1'b0, e17: 87, o17: 1'b0};
    tbl[1] = '{len: 8'd4, b: {16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, gap: 1'b1,
               e24: 131068, o24: 1'b0, e17: 65535, o17: 1'b1};
    tbl[2] = '{len: 8'd3, b: {16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, gap: 1'b0,
               e24: 98301, o24: 1'b0, e17: 65535, o17: 1'b1};
    tbl[3] = '{len: 8'd1, b: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, gap: 1'b0,
               e24: -1, o24: 1'b0, e17: -1, o17: 1'b0};
    tbl[4] = '{len: 8'd3, b: {16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000}, gap: 1'b1,
               e24: -98304, o24: 1'b0, e17: -65536, o17: 1'b1};
    tbl[5] = '{len: 8'd4, b: {16'h0000, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, gap: 1'b0,
               e24: 98300, o24: 1'b0, e17: 65534, o17: 1'b1};
    tbl[6] = '{len: 8'd0, b: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, gap: 1'b0,
               e24: 0, o24: 1'b0, e17: 0, o17: 1'b0};

    reset = 1'b0; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_acc_a", acc_a, 0);
    chk("rst_acc_b", acc_b, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_busy", busy_b, 0);
    chk("rst_ovf", ovf_a, 0);
    reset = 1'b1;

    // Data offered while idle must be ignored.
    in_valid = 1'b1;
    in_data  = 16'd500;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    chk("idle_ignore_acc", acc_a, 0);
    chk("idle_ignore_busy", busy_a, 0);

    for (int v = 0; v < 7; v++) begin
      do_start(tbl[v].len);
      for (int i = 0; i < int'(tbl[v].len); i++) begin
        send_beat(tbl[v].b[i], tbl[v].gap && (i < int'(tbl[v].len) - 1));
      end
      check_done(tbl[v].e24, tbl[v].o24, tbl[v].e17, tbl[v].o17);
      release_done(tbl[v].e24);
    end

    // DONE holds through back-pressure and ignores start.
    do_start(8'd2);
    send_beat(16'd5, 1'b0);
    send_beat(16'd6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 8'd3;
      tick();
      chk("hold_valid", out_valid_a, 1);
      chk("hold_acc", acc_a, 11);
      chk("hold_in_ready", in_ready_a, 0);
    end
    start = 1'b0;
    release_done(11);
    tick();
    chk("no_restart", busy_a, 0);

    // Reset mid-operation wins over start, data and out_ready.
    do_start(8'd5);
    send_beat(16'd10, 1'b0);
    send_beat(16'd20, 1'b0);
    reset = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("mid_rst_acc_a", acc_a, 0);
    chk("mid_rst_acc_b", acc_b, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_in_ready", in_ready_a, 0);
    chk("mid_rst_valid", out_valid_b, 0);
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_valid", out_valid_a, 0);
    end
    in_valid = 1'b0;
    do_start(8'd2);
    send_beat(16'd10, 1'b0);
    send_beat(16'd20, 1'b0);
    check_done(30, 1'b0, 30, 1'b0);
    release_done(30);

    // Maximum length must terminate without wrapping the count.
    do_start(8'd255);
    for (int i = 0; i < 255; i++) send_beat(16'd1, 1'b0);
    check_done(255, 1'b0, 255, 1'b0);
    release_done(255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
